kbd_ctrl: RTL

KBD_CTRL -- requirements
Module: kbd_ctrl

---
 rtl/kbd_pkg.sv | 46 ++++
 rtl/kbd_watchdog.sv | 34 +++
 rtl/kbd_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/kbd_pkg.sv
// Shared types and scan-code constants for the PS/2 keyboard decoder.
package kbd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } state_t;

  // Prefix bytes
  localparam logic [7:0] PFX_E0 = 8'hE0;
  localparam logic [7:0] PFX_E1 = 8'hE1;
  localparam logic [7:0] PFX_F0 = 8'hF0;

  // Controller chatter that never represents a key when seen in IDLE
  localparam logic [7:0] IGN_00 = 8'h00;
  localparam logic [7:0] IGN_AA = 8'hAA;
  localparam logic [7:0] IGN_EE = 8'hEE;
  localparam logic [7:0] IGN_FA = 8'hFA;
  localparam logic [7:0] IGN_FE = 8'hFE;
  localparam logic [7:0] IGN_FF = 8'hFF;

  // Held-key scan codes (left/right are E0-extended, fire/enter are not)
  localparam logic [7:0] CODE_LEFT  = 8'h6B;
  localparam logic [7:0] CODE_RIGHT = 8'h74;
  localparam logic [7:0] CODE_FIRE  = 8'h29;
  localparam logic [7:0] CODE_ENTER = 8'h5A;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       make;
  } key_event_t;

  function automatic logic is_ignored(input logic [7:0] b);
    return (b == IGN_00) || (b == IGN_AA) || (b == IGN_EE) ||
           (b == IGN_FA) || (b == IGN_FE) || (b == IGN_FF);
  endfunction

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PFX_E0) || (b == PFX_E1) || (b == PFX_F0);
  endfunction

endpackage

// File: rtl/kbd_watchdog.sv
// Stalled-frame watchdog: fires when the receiver stays busy without
// delivering a byte for TIMEOUT_CYC consecutive cycles.
module kbd_watchdog
  #(parameter int unsigned TIMEOUT_CYC = 100000)
  (
    input  logic clk,
    input  logic reset,
    input  logic rx_busy,
    input  logic rx_valid,
    output logic expire
  );

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  // Expiry is suppressed by rx_valid so a byte arriving on the last cycle wins
  always_comb begin
    expire = rx_busy && !rx_valid && (cnt == LAST);
  end

  // Stall counter: runs only while a frame is in progress with no byte
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (!rx_busy || rx_valid || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/kbd_ctrl.sv
// PS/2 scan-code set 2 decoder: prefix FSM, key events, held-key levels,
// error counting and receiver restart on stalled frames.
module kbd_ctrl
  import kbd_pkg::*;
  #(
    parameter int unsigned TIMEOUT_CYC = 100000,
    parameter int unsigned PAUSE_SKIP  = 7
  )
  (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    input  logic       rx_busy,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_make,
    output logic       key_valid,
    output logic       key_left,
    output logic       key_right,
    output logic       key_fire,
    output logic       key_enter,
    output logic       rx_restart,
    output logic [7:0] err_cnt
  );

  localparam logic [7:0] SKIP_LOAD = 8'(PAUSE_SKIP);

  state_t     state, state_next;
  logic [7:0] skip_cnt, skip_next;
  logic       emit;
  key_event_t evt;
  logic       proto_err;
  logic       expire;

  kbd_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .rx_busy  (rx_busy),
    .rx_valid (rx_valid),
    .expire   (expire)
  );

  // Next-state decode; a received byte takes priority over a watchdog expiry
  always_comb begin
    state_next = state;
    skip_next  = skip_cnt;
    emit       = 1'b0;
    evt        = '0;
    proto_err  = 1'b0;

    if (rx_valid) begin
      case (state)
        ST_IDLE: begin
          if (rx_byte == PFX_E0) begin
            state_next = ST_EXT;
          end else if (rx_byte == PFX_F0) begin
            state_next = ST_BRK;
          end else if (rx_byte == PFX_E1) begin
            if (SKIP_LOAD != '0) begin
              state_next = ST_SKIP;
              skip_next  = SKIP_LOAD;
            end
          end else if (!is_ignored(rx_byte)) begin
            emit     = 1'b1;
            evt.code = rx_byte;
            evt.ext  = 1'b0;
            evt.make = 1'b1;
          end
        end

        ST_EXT: begin
          state_next = ST_IDLE;
          if (rx_byte == PFX_F0) begin
            state_next = ST_EXT_BRK;
          end else if (rx_byte == PFX_E0) begin
            state_next = ST_EXT;
          end else if (rx_byte == PFX_E1 || rx_byte == IGN_00 || rx_byte == IGN_FF) begin
            proto_err = 1'b1;
          end else begin
            emit     = 1'b1;
            evt.code = rx_byte;
            evt.ext  = 1'b1;
            evt.make = 1'b1;
          end
        end

        ST_BRK, ST_EXT_BRK: begin
          state_next = ST_IDLE;
          if (is_prefix(rx_byte)) begin
            proto_err = 1'b1;
          end else begin
            emit     = 1'b1;
            evt.code = rx_byte;
            evt.ext  = (state == ST_EXT_BRK);
            evt.make = 1'b0;
          end
        end

        ST_SKIP: begin
          skip_next = skip_cnt - 1'b1;
          if (skip_cnt <= 8'd1) begin
            skip_next  = '0;
            state_next = ST_IDLE;
          end
        end

        default: begin
          state_next = ST_IDLE;
          skip_next  = '0;
        end
      endcase
    end else if (expire) begin
      state_next = ST_IDLE;
      skip_next  = '0;
    end
  end

  // FSM and skip-counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      skip_cnt <= '0;
    end else begin
      state    <= state_next;
      skip_cnt <= skip_next;
    end
  end

  // Event outputs: registered one cycle after the completing byte
  always_ff @(posedge clk) begin
    if (reset) begin
      key_valid <= 1'b0;
      key_code  <= '0;
      key_ext   <= 1'b0;
      key_make  <= 1'b0;
    end else begin
      key_valid <= emit;
      if (emit) begin
        key_code <= evt.code;
        key_ext  <= evt.ext;
        key_make <= evt.make;
      end
    end
  end

  // Held-key levels follow make/break events; a timeout leaves them alone
  always_ff @(posedge clk) begin
    if (reset) begin
      key_left  <= 1'b0;
      key_right <= 1'b0;
      key_fire  <= 1'b0;
      key_enter <= 1'b0;
    end else if (emit) begin
      if (evt.ext && evt.code == CODE_LEFT)   key_left  <= evt.make;
      if (evt.ext && evt.code == CODE_RIGHT)  key_right <= evt.make;
      if (!evt.ext && evt.code == CODE_FIRE)  key_fire  <= evt.make;
      if (!evt.ext && evt.code == CODE_ENTER) key_enter <= evt.make;
    end
  end

  // Restart pulse and saturating error counter (error and timeout count once)
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_restart <= 1'b0;
      err_cnt    <= '0;
    end else begin
      rx_restart <= expire;
      if ((proto_err || expire) && (err_cnt != '1)) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule
